// File: rtl/l2_cache_wbuf.sv
// Set-associative write-back, write-allocate L2 cache with tree pseudo-LRU
// and a one-entry victim write buffer drained when the upstream bus is idle.
module l2_cache_wbuf #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_index  = 3,
    parameter int unsigned s_assoc  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     mem_address,
    input  logic [8*(2**s_offset)-1:0]      mem_wdata,
    input  logic                            mem_read,
    input  logic                            mem_write,
    output logic [8*(2**s_offset)-1:0]      mem_rdata,
    output logic                            mem_resp,
    output logic [31:0]                     pmem_address,
    output logic [8*(2**s_offset)-1:0]      pmem_wdata,
    output logic                            pmem_read,
    output logic                            pmem_write,
    input  logic                            pmem_resp,
    input  logic [8*(2**s_offset)-1:0]      pmem_rdata,
    output logic                            wb_pending
);

    localparam int unsigned s_tag  = 32 - s_offset - s_index;
    localparam int unsigned s_line = 8 * (2 ** s_offset);
    localparam int unsigned s_sets = 2 ** s_index;
    localparam int unsigned WAY_W  = $clog2(s_assoc);
    localparam int unsigned P_W    = s_assoc - 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_FILL   = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    // Storage: data/tag arrays are not reset, state bits are
    logic [s_line-1:0] data_arr [s_sets][s_assoc];
    logic [s_tag-1:0]  tag_arr  [s_sets][s_assoc];

    logic [s_sets-1:0][s_assoc-1:0] valid_q, valid_d;
    logic [s_sets-1:0][s_assoc-1:0] dirty_q, dirty_d;
    logic [s_sets-1:0][P_W-1:0]     plru_q, plru_d;

    logic [1:0]        state_q, state_d;
    logic              wb_valid_q, wb_valid_d;
    logic [31:0]       wb_addr_q, wb_addr_d;
    logic [s_line-1:0] wb_data_q, wb_data_d;
    logic [WAY_W-1:0]  fill_way_q, fill_way_d;

    logic [s_index-1:0] req_idx;
    logic [s_tag-1:0]   req_tag;
    logic [31:0]        line_addr;
    logic               req_any;
    logic               req_rd;
    logic               unused_offset;

    logic [s_assoc-1:0] hit_vec;
    logic [s_assoc-1:0] valid_row;
    logic [s_assoc-1:0] sh_hit;
    logic [s_assoc-1:0] sh_inv;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   inv_way;
    logic               has_inv;
    logic [WAY_W-1:0]   victim_way;

    logic               arr_we;
    logic [WAY_W-1:0]   arr_way;
    logic [s_line-1:0]  arr_data;

    // Walk the tree from the root following node bits to the victim leaf
    function automatic logic [WAY_W-1:0] plru_victim(input logic [P_W-1:0] bits);
        int unsigned  node;
        logic [P_W-1:0] sh;
        node = 0;
        for (int l = 0; l < int'(WAY_W); l++) begin
            sh   = bits >> node;
            node = 2 * node + 1 + (sh[0] ? 1 : 0);
        end
        return WAY_W'(node - P_W);
    endfunction

    // Point every node on the accessed way's path away from that way
    function automatic logic [P_W-1:0] plru_touch(input logic [P_W-1:0] bits,
                                                  input logic [WAY_W-1:0] way);
        int unsigned      node;
        logic [WAY_W-1:0] sw;
        logic [P_W-1:0]   mask;
        logic [P_W-1:0]   res;
        res  = bits;
        node = 0;
        for (int l = 0; l < int'(WAY_W); l++) begin
            sw   = way >> (int'(WAY_W) - 1 - l);
            mask = P_W'(1) << node;
            if (sw[0]) res = res & ~mask;
            else       res = res | mask;
            node = 2 * node + 1 + (sw[0] ? 1 : 0);
        end
        return res;
    endfunction

    assign req_idx       = mem_address[s_offset+s_index-1:s_offset];
    assign req_tag       = mem_address[31:s_offset+s_index];
    assign line_addr     = {mem_address[31:s_offset], {s_offset{1'b0}}};
    assign req_any       = mem_read | mem_write;
    assign req_rd        = mem_read;
    assign unused_offset = ^mem_address[s_offset-1:0];
    assign valid_row     = valid_q[req_idx];
    assign wb_pending    = wb_valid_q;

    // Per-way tag compare on the indexed set
    for (genvar g = 0; g < s_assoc; g++) begin : g_cmp
        assign hit_vec[g] = valid_q[req_idx][g] && (tag_arr[req_idx][g] == req_tag);
    end

    // Hit way encode and lowest-index invalid way
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        has_inv = 1'b0;
        sh_hit  = '0;
        sh_inv  = '0;
        for (int w = int'(s_assoc) - 1; w >= 0; w--) begin
            sh_hit = hit_vec >> w;
            sh_inv = ~valid_row >> w;
            if (sh_hit[0]) hit_way = WAY_W'(w);
            if (sh_inv[0]) begin
                inv_way = WAY_W'(w);
                has_inv = 1'b1;
            end
        end
        hit        = |hit_vec;
        victim_way = has_inv ? inv_way : plru_victim(plru_q[req_idx]);
    end

    // Next-state, array updates and response outputs
    always_comb begin
        state_d      = state_q;
        wb_valid_d   = wb_valid_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        fill_way_d   = fill_way_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        plru_d       = plru_q;
        arr_we       = 1'b0;
        arr_way      = hit_way;
        arr_data     = mem_wdata;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = line_addr;
        pmem_wdata   = wb_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_any)         state_d = ST_LOOKUP;
                else if (wb_valid_q) state_d = ST_DRAIN;
            end
            ST_LOOKUP: begin
                state_d = ST_IDLE;
                if (req_any && hit) begin
                    mem_resp        = 1'b1;
                    plru_d[req_idx] = plru_touch(plru_q[req_idx], hit_way);
                    if (req_rd) begin
                        mem_rdata = data_arr[req_idx][hit_way];
                    end else begin
                        arr_we                    = 1'b1;
                        dirty_d[req_idx][hit_way] = 1'b1;
                    end
                end else if (req_any && wb_valid_q) begin
                    // Buffer must be empty before a new victim can be evicted
                    state_d = ST_DRAIN;
                end else if (req_any) begin
                    if (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) begin
                        wb_valid_d = 1'b1;
                        wb_addr_d  = {tag_arr[req_idx][victim_way], req_idx, {s_offset{1'b0}}};
                        wb_data_d  = data_arr[req_idx][victim_way];
                    end
                    if (req_rd) begin
                        fill_way_d = victim_way;
                        state_d    = ST_FILL;
                    end else begin
                        // Full-line write installs without a fetch
                        arr_we                       = 1'b1;
                        arr_way                      = victim_way;
                        valid_d[req_idx][victim_way] = 1'b1;
                        dirty_d[req_idx][victim_way] = 1'b1;
                        plru_d[req_idx]              = plru_touch(plru_q[req_idx], victim_way);
                        mem_resp                     = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    arr_we                       = 1'b1;
                    arr_way                      = fill_way_q;
                    arr_data                     = pmem_rdata;
                    valid_d[req_idx][fill_way_q] = 1'b1;
                    dirty_d[req_idx][fill_way_q] = 1'b0;
                    plru_d[req_idx]              = plru_touch(plru_q[req_idx], fill_way_q);
                    mem_resp                     = 1'b1;
                    mem_rdata                    = pmem_rdata;
                    state_d                      = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = wb_addr_q;
                if (pmem_resp) begin
                    wb_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= 1'b0;
            valid_q    <= '0;
            dirty_q    <= '0;
            plru_q     <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            plru_q     <= plru_d;
        end
    end

    // Buffer payload and fill way need no reset
    always_ff @(posedge clk) begin
        wb_addr_q  <= wb_addr_d;
        wb_data_q  <= wb_data_d;
        fill_way_q <= fill_way_d;
    end

    // Data and tag array write port
    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_arr[req_idx][arr_way] <= arr_data;
            tag_arr[req_idx][arr_way]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_l2_cache_wbuf.sv
// Scoreboard bench for l2_cache_wbuf: directed requests push expected
// upstream responses and memory transactions; monitors pop and compare.
module tb_l2_cache_wbuf;

    localparam int unsigned OFF   = 5;
    localparam int unsigned IDX   = 3;
    localparam int unsigned ASSOC = 8;
    localparam int unsigned LINE  = 256;
    localparam int          MEM_LAT = 3;
    localparam int          TMO     = 200;

    logic            clk;
    logic            rst;
    logic [31:0]     mem_address;
    logic [LINE-1:0] mem_wdata;
    logic            mem_read;
    logic            mem_write;
    logic [LINE-1:0] mem_rdata;
    logic            mem_resp;
    logic [31:0]     pmem_address;
    logic [LINE-1:0] pmem_wdata;
    logic            pmem_read;
    logic            pmem_write;
    logic            pmem_resp;
    logic [LINE-1:0] pmem_rdata;
    logic            wb_pending;

    l2_cache_wbuf #(.s_offset(OFF), .s_index(IDX), .s_assoc(ASSOC)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .wb_pending   (wb_pending)
    );

    typedef struct {
        bit              rd;
        logic [LINE-1:0] data;
        int              lat;
        bit              pm;
    } up_t;

    typedef struct {
        bit              wr;
        logic [31:0]     addr;
        logic [LINE-1:0] data;
    } pm_t;

    up_t             up_q[$];
    pm_t             pm_q[$];
    logic [LINE-1:0] mem_model [logic [31:0]];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LINE-1:0] pat(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [LINE-1:0] wdat(input int k);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(k);
        return {8{w}};
    endfunction

    task automatic check(input string nm, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model: responds after MEM_LAT cycles, checks each transaction
    initial begin
        int  cnt;
        pm_t e;
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                cnt       = 0;
            end else if (!(pmem_read || pmem_write)) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == MEM_LAT) begin
                    pmem_resp = 1'b1;
                    if (pm_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pmem_unexpected: got wr=%0b addr=0x%h expected no transaction",
                                 pmem_write, pmem_address);
                    end else begin
                        e = pm_q.pop_front();
                        check("pmem_is_write", LINE'(pmem_write), LINE'(e.wr));
                        check("pmem_address", LINE'(pmem_address), LINE'(e.addr));
                        if (e.wr) check("pmem_wdata", pmem_wdata, e.data);
                    end
                    if (pmem_write) mem_model[pmem_address] = pmem_wdata;
                    else pmem_rdata = mem_model.exists(pmem_address) ? mem_model[pmem_address]
                                                                     : pat(pmem_address);
                end
            end
        end
    end

    // Upstream monitor: pops the expectation on every mem_resp
    initial begin
        int  rc;
        up_t e;
        rc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rc = 0;
            end else begin
                if (mem_read || mem_write) rc++;
                if (mem_resp) begin
                    if (up_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL resp_unexpected: got mem_resp=1 expected none");
                    end else begin
                        e = up_q.pop_front();
                        if (e.rd) check("mem_rdata", mem_rdata, e.data);
                        if (e.lat != 0) check("resp_latency", LINE'(rc), LINE'(e.lat));
                        check("resp_with_pmem_resp", LINE'(pmem_resp), LINE'(e.pm));
                    end
                    rc = 0;
                end
            end
        end
    end

    task automatic pm_exp(input bit wr, input logic [31:0] a, input logic [LINE-1:0] d);
        pm_t e;
        e.wr = wr; e.addr = a; e.data = d;
        pm_q.push_back(e);
    endtask

    // Issue one request (called at posedge+1), hold until mem_resp
    task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [LINE-1:0] wd, input logic [LINE-1:0] exp,
                       input int lat, input bit pm);
        up_t e;
        int  cyc;
        e.rd = rd; e.data = exp; e.lat = lat; e.pm = pm;
        up_q.push_back(e);
        mem_address = a;
        mem_wdata   = wd;
        mem_read    = rd;
        mem_write   = wr;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!mem_resp && cyc < TMO);
        if (!mem_resp) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no mem_resp for 0x%h after %0d cycles expected a response", a, cyc);
            void'(up_q.pop_back());
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mem_resp",   LINE'(mem_resp),   '0);
        check("rst_pmem_read",  LINE'(pmem_read),  '0);
        check("rst_pmem_write", LINE'(pmem_write), '0);
        check("rst_wb_pending", LINE'(wb_pending), '0);
        check("rst_mem_rdata",  mem_rdata,         '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Wait until all expected memory traffic completed and the bus is quiet
    task automatic wait_quiet();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while ((pm_q.size() != 0 || pmem_read || pmem_write) && cyc < TMO);
        if (pm_q.size() != 0 || pmem_read || pmem_write) begin
            checks++;
            errors++;
            $display("FAIL quiet_timeout: got %0d pending memory ops expected 0", pm_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill_set0();
        for (int k = 0; k < 8; k++)
            req(1'b0, 1'b1, 32'(k) << 8, wdat(k), '0, 2, 1'b0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = '0; mem_wdata = '0;

        do_reset();

        // Cold read fill, then hit
        pm_exp(1'b0, 32'h40, '0);
        req(1'b1, 1'b0, 32'h0000_0044, '0, pat(32'h40), 0, 1'b1);
        req(1'b1, 1'b0, 32'h0000_0040, '0, pat(32'h40), 2, 1'b0);

        // Write miss installs without fetch; read-wins when both asserted
        req(1'b0, 1'b1, 32'h60, wdat(50), '0, 2, 1'b0);
        req(1'b1, 1'b0, 32'h60, '0, wdat(50), 2, 1'b0);
        req(1'b1, 1'b1, 32'h60, wdat(99), wdat(50), 2, 1'b0);
        req(1'b1, 1'b0, 32'h60, '0, wdat(50), 2, 1'b0);

        // Dirty eviction: fetch first, write back afterwards
        fill_set0();
        pm_exp(1'b0, 32'h800, '0);
        pm_exp(1'b1, 32'h000, wdat(0));
        req(1'b1, 1'b0, 32'h800, '0, pat(32'h800), 0, 1'b1);
        @(negedge clk);
        check("wb_pending_after_evict", LINE'(wb_pending), LINE'(1));
        wait_quiet();
        check("wb_pending_after_drain", LINE'(wb_pending), '0);

        // Re-read the written-back line: victim way 4 (0x400) goes to buffer
        pm_exp(1'b0, 32'h000, '0);
        pm_exp(1'b1, 32'h400, wdat(4));
        req(1'b1, 1'b0, 32'h000, '0, wdat(0), 0, 1'b1);
        wait_quiet();
        check("wb_pending_after_drain2", LINE'(wb_pending), '0);

        // Reset in the middle of a fill
        do_reset();
        mem_address = 32'h44;
        mem_read    = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!pmem_read && cyc < TMO);
        check("fill_started", LINE'(pmem_read), LINE'(1));
        rst      = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_fill_pmem_read", LINE'(pmem_read), '0);
        check("rst_fill_mem_resp",  LINE'(mem_resp),  '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pm_exp(1'b0, 32'h40, '0);
        req(1'b1, 1'b0, 32'h40, '0, pat(32'h40), 0, 1'b1);

        // Back-to-back misses: drain completes before second fetch
        do_reset();
        fill_set0();
        pm_exp(1'b0, 32'h800, '0);
        pm_exp(1'b1, 32'h000, wdat(0));
        pm_exp(1'b0, 32'h900, '0);
        pm_exp(1'b1, 32'h400, wdat(4));
        req(1'b1, 1'b0, 32'h800, '0, pat(32'h800), 0, 1'b1);
        req(1'b1, 1'b0, 32'h900, '0, pat(32'h900), 0, 1'b1);
        @(negedge clk);
        check("wb_pending_after_900", LINE'(wb_pending), LINE'(1));
        wait_quiet();
        check("wb_pending_final", LINE'(wb_pending), '0);

        cyc = 0;
        while (up_q.size() != 0 && cyc < TMO) begin
            @(negedge clk);
            cyc++;
        end
        check("responses_outstanding", LINE'(up_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l2_cache_wbuf.md
Name: l2_cache_wbuf

Overview:
- Parametrised set-associative, write-back, write-allocate L2 cache in a single self-contained module (FSM + arrays), sitting between the L1 arbiter and physical memory.
- Successor to the current L2. Adds a tree pseudo-LRU of any power-of-two associativity.
- Adds a one-entry victim write buffer so a dirty miss fetches first and writes back later.
- A full-line write miss installs without a fetch.

Parameters:
s_offset  5   byte-offset bits; line = 2**s_offset bytes
s_index   3   set-index bits; sets = 2**s_index
s_assoc   8   ways; power of two, >= 2
s_tag     32-s_offset-s_index   tag width (derived)
s_line    8*2**s_offset   line width in bits (derived)

Ports:
clk           in   1       clock
rst           in   1       synchronous active-high reset
mem_address   in   32      upstream line address; low s_offset bits ignored
mem_wdata     in   s_line  full-line write data
mem_read      in   1       upstream read request, held until mem_resp
mem_write     in   1       upstream write request, held until mem_resp
mem_rdata     out  s_line  read data, valid while mem_resp=1
mem_resp      out  1       one-cycle completion pulse
pmem_address  out  32      memory line address, low s_offset bits always 0
pmem_wdata    out  s_line  writeback data
pmem_read     out  1       memory read, held until pmem_resp
pmem_write    out  1       memory write, held until pmem_resp
pmem_resp     in   1       memory completion pulse
pmem_rdata    in   s_line  fill data, valid with pmem_resp
wb_pending    out  1       victim buffer holds an undrained dirty line

Behaviour:
Reset:
- Clears all valid, dirty and PLRU bits and wb_valid. State goes to IDLE.
- All 1-bit outputs are 0 and mem_rdata is 0 from the cycle after rst.
- Data and tag arrays are not reset.
- Reset mid-FILL or mid-DRAIN abandons the transaction; pmem_read/pmem_write drop the next cycle and buffered dirty data is lost.

Requests:
- mem_read and mem_write are never asserted together. If both are asserted, read wins.
- A request is held until mem_resp. mem_resp lasts exactly one cycle.

States:
- IDLE: if a request is present, go to LOOKUP; requests have priority over draining. Otherwise, if wb_valid, go to DRAIN. Otherwise stay in IDLE.
- LOOKUP: combinational tag compare across all ways of the indexed set.
  - Hit, read: mem_resp=1, mem_rdata = way line, PLRU update, go to IDLE. Hit latency is 2 cycles: response in the 2nd cycle the request is high.
  - Hit, write: overwrite line, set dirty, mem_resp=1, PLRU update, go to IDLE.
  - Miss with wb_valid=1: go to DRAIN, no response; after the drain the request is re-looked-up via IDLE.
  - Miss with wb_valid=0: pick the victim (lowest-index invalid way, else PLRU). If the victim is valid and dirty, copy its line and address {tag,index,0} into the buffer and set wb_valid.
    - Write: install mem_wdata, tag, valid=1, dirty=1; mem_resp=1; PLRU update; go to IDLE. No pmem traffic.
    - Read: go to FILL.
- FILL: pmem_read=1, pmem_address = line-aligned mem_address.
  - On pmem_resp, in the same cycle: write the line, tag, valid=1, dirty=0; mem_resp=1; mem_rdata = pmem_rdata; PLRU update; go to IDLE.
- DRAIN: pmem_write=1, pmem_address and pmem_wdata from the buffer.
  - On pmem_resp: clear wb_valid, go to IDLE.
  - Not interruptible.

Buffer coherence:
- An evicted line is absent from the arrays.
- Any access to that address misses, and the miss drains the buffer before refetching, so no stale read is possible.

PLRU:
- Each set holds s_assoc-1 tree bits. A node bit of 0 selects the lower half as the victim side.
- On each access to way w, every node on w's path is set to point away from w.

Index and tag:
- index = addr[s_offset+s_index-1 : s_offset].
- tag = addr[31 : s_offset+s_index].

Test Plan:
1. Cold read 0x0000_0044 -> pmem_read with pmem_address 0x40; pmem_resp with data A -> mem_resp in the same cycle with mem_rdata=A. Re-read of 0x40 -> mem_resp in the 2nd request cycle, no pmem activity.
2. Write miss 0x60 with data B -> no pmem activity, mem_resp in the 2nd cycle. Read 0x60 -> hit, mem_rdata=B.
3. Write misses 0x000, 0x100, …, 0x700 (set 0, all dirty), then read 0x800 -> pmem_read 0x800 first (no write before it). Victim is way 0, so the buffer holds 0x000 and wb_pending=1. With the bus idle -> pmem_write 0x000 with the line-0 data, then wb_pending=0.
4. As in 3, but read 0x900 issued the cycle after the 0x800 response -> pmem_write 0x000 completes before pmem_read 0x900. The 0x900 victim is way 4, so buffered address 0x400.
5. rst during FILL -> pmem_read=0 and mem_resp=0 the next cycle. A following read of 0x40 misses.
6. Re-read 0x000 after scenario 3 -> miss, refetch, mem_rdata equals the written-back data supplied by the memory model.
